rampa_level_receiver: RTL and testbench

//  Receiving end of the ramp-start speed interface: consumes the one-hot level

---
 rtl/rampa_level_receiver_if.sv | 23 ++
 rtl/rampa_level_receiver.sv | 136 +++++++++++++
 tb/tb_rampa_level_receiver.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/rampa_level_receiver_if.sv
// Speed-interface bundle between the ramp-start FSM side and the level receiver.
interface rampa_level_receiver_if;
  logic       ena;
  logic       tick;
  logic       lvl_30;
  logic       lvl_50;
  logic       lvl_100;
  logic       clear_fault;
  logic       pwm_out;
  logic [1:0] level;
  logic       fault;
  logic [1:0] fault_code;

  modport master (
    output ena, tick, lvl_30, lvl_50, lvl_100, clear_fault,
    input  pwm_out, level, fault, fault_code
  );

  modport slave (
    input  ena, tick, lvl_30, lvl_50, lvl_100, clear_fault,
    output pwm_out, level, fault, fault_code
  );
endinterface

// File: rtl/rampa_level_receiver.sv
// Level receiver: checks the one-hot ramp protocol on the lvl_* lines and
// turns the decoded level into a period-aligned PWM motor drive.
module rampa_level_receiver #(
  parameter int PWM_PERIOD = 100,
  parameter int MIN_DWELL  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  rampa_level_receiver_if.slave  bus
);
  localparam int CW = $clog2(PWM_PERIOD + 1);
  localparam logic [CW-1:0] D30  = CW'(PWM_PERIOD * 30 / 100);
  localparam logic [CW-1:0] D50  = CW'(PWM_PERIOD * 50 / 100);
  localparam logic [CW-1:0] D100 = CW'(PWM_PERIOD);
  localparam logic [CW-1:0] CMAX = CW'(PWM_PERIOD - 1);
  localparam logic [3:0]    DMIN = 4'(MIN_DWELL);

  typedef enum logic [2:0] {IDLE, RUN30, RUN50, RUN100, FAULT} state_t;

  state_t        r_state;
  logic [2:0]    r_lvl_q;  // {30, 50, 100}
  logic [3:0]    r_dwell;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_duty;
  logic          r_pwm;
  logic [1:0]    r_level;
  logic          r_fault;
  logic [1:0]    r_code;

  state_t        w_next;
  logic [1:0]    w_code_n;
  logic [1:0]    w_tgt;
  logic [1:0]    w_cur;
  logic          w_multi;
  logic          w_run_n;
  logic [CW-1:0] w_duty_n;

  function automatic logic [1:0] st2lvl(input state_t s);
    case (s)
      RUN30:   return 2'd1;
      RUN50:   return 2'd2;
      RUN100:  return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic state_t lvl2st(input logic [1:0] l);
    case (l)
      2'd1:    return RUN30;
      2'd2:    return RUN50;
      2'd3:    return RUN100;
      default: return IDLE;
    endcase
  endfunction

  always_comb begin
    w_multi = (r_lvl_q[2] & r_lvl_q[1]) | (r_lvl_q[2] & r_lvl_q[0]) |
              (r_lvl_q[1] & r_lvl_q[0]);
    case (r_lvl_q)
      3'b100:  w_tgt = 2'd1;
      3'b010:  w_tgt = 2'd2;
      3'b001:  w_tgt = 2'd3;
      default: w_tgt = 2'd0;
    endcase
    w_cur    = st2lvl(r_state);
    w_next   = r_state;
    w_code_n = r_code;
    if (r_state == FAULT) begin
      if (bus.clear_fault && r_lvl_q == 3'b000) begin
        w_next   = IDLE;
        w_code_n = 2'd0;
      end
    end else if (w_multi) begin
      w_next   = FAULT;
      w_code_n = 2'd1;
    end else if ({1'b0, w_tgt} > {1'b0, w_cur} + 3'd1) begin
      w_next   = FAULT;
      w_code_n = 2'd2;
    end else if ({1'b0, w_tgt} == {1'b0, w_cur} + 3'd1 &&
                 r_state != IDLE && r_dwell < DMIN) begin
      // Starting from IDLE has no dwell requirement; only RUNx up-steps do.
      w_next   = FAULT;
      w_code_n = 2'd3;
    end else begin
      w_next = lvl2st(w_tgt);
    end
    w_run_n = (w_next == RUN30) || (w_next == RUN50) || (w_next == RUN100);
    case (w_next)
      RUN30:   w_duty_n = D30;
      RUN50:   w_duty_n = D50;
      RUN100:  w_duty_n = D100;
      default: w_duty_n = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_lvl_q <= '0;
      r_dwell <= '0;
      r_cnt   <= '0;
      r_duty  <= '0;
      r_pwm   <= 1'b0;
      r_level <= '0;
      r_fault <= 1'b0;
      r_code  <= '0;
    end else if (bus.ena) begin
      r_lvl_q <= {bus.lvl_30, bus.lvl_50, bus.lvl_100};
      r_state <= w_next;
      r_code  <= w_code_n;
      r_fault <= (w_next == FAULT);
      r_level <= st2lvl(w_next);
      // A state change clears dwell even if a tick lands in the same cycle.
      if (w_next != r_state)
        r_dwell <= '0;
      else if (bus.tick && w_run_n && r_dwell < DMIN)
        r_dwell <= r_dwell + 4'd1;
      r_cnt <= (r_cnt == CMAX) ? '0 : r_cnt + 1'b1;
      if (!w_run_n) begin
        r_duty <= '0;
        r_pwm  <= 1'b0;
      end else begin
        // Duty only updates at the period boundary so pulses are never clipped.
        if (r_cnt == CMAX) r_duty <= w_duty_n;
        r_pwm <= (r_cnt < r_duty);
      end
    end else begin
      r_pwm <= 1'b0;
    end
  end

  assign bus.pwm_out    = r_pwm;
  assign bus.level      = r_level;
  assign bus.fault      = r_fault;
  assign bus.fault_code = r_code;
endmodule

// File: tb/tb_rampa_level_receiver.sv
// Directed bench for the level receiver with PWM_PERIOD=10, MIN_DWELL=2.
module tb_rampa_level_receiver;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;

  rampa_level_receiver_if bus();

  rampa_level_receiver #(.PWM_PERIOD(10), .MIN_DWELL(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Order is {lvl_30, lvl_50, lvl_100}.
  task automatic lines(input logic [2:0] v);
    {bus.lvl_30, bus.lvl_50, bus.lvl_100} = v;
  endtask

  task automatic tick_pulse();
    bus.tick = 1'b1;
    cyc(1);
    bus.tick = 1'b0;
  endtask

  task automatic count10(output int n);
    n = 0;
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      n += int'(bus.pwm_out);
    end
  endtask

  task automatic wait_rise(output logic found);
    logic p;
    p = bus.pwm_out;
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      cyc(1);
      if (bus.pwm_out && !p) begin
        found = 1'b1;
        break;
      end
      p = bus.pwm_out;
    end
  endtask

  task automatic hi_run(output int len);
    len = 1;
    for (int k = 0; k < 20; k++) begin
      cyc(1);
      if (!bus.pwm_out) break;
      len++;
    end
  endtask

  task automatic clear_to_idle();
    lines(3'b000);
    bus.clear_fault = 1'b1;
    cyc(2);
    bus.clear_fault = 1'b0;
  endtask

  initial begin
    int   n;
    logic f;
    bus.ena = 1'b0; bus.tick = 1'b0; bus.clear_fault = 1'b0;
    lines(3'b000);
    cyc(2);
    chk("rst_level", bus.level, 0);
    chk("rst_fault", bus.fault, 0);
    chk("rst_code",  bus.fault_code, 0);
    chk("rst_pwm",   bus.pwm_out, 0);
    reset = 1'b0;
    bus.ena = 1'b1;

    // 1) legal ramp 30 -> 50 -> 100
    lines(3'b100); cyc(2);
    chk("t1_lvl30", bus.level, 1);
    cyc(11); count10(n);
    chk("t1_duty30", n, 3);
    tick_pulse(); tick_pulse();
    lines(3'b010); cyc(2);
    chk("t1_lvl50", bus.level, 2);
    cyc(11); count10(n);
    chk("t1_duty50", n, 5);
    tick_pulse(); tick_pulse();
    lines(3'b001); cyc(2);
    chk("t1_lvl100", bus.level, 3);
    cyc(11); count10(n);
    chk("t1_duty100", n, 10);
    chk("t1_nofault", bus.fault, 0);

    // 2) skipped level from IDLE
    lines(3'b000); cyc(2);
    chk("t2_idle", bus.level, 0);
    chk("t2_idle_pwm", bus.pwm_out, 0);
    lines(3'b001); cyc(2);
    chk("t2_fault", bus.fault, 1);
    chk("t2_code", bus.fault_code, 2);
    chk("t2_level", bus.level, 0);
    chk("t2_pwm", bus.pwm_out, 0);
    clear_to_idle();
    chk("t2_cleared", bus.fault, 0);

    // 3) multi-hot, clear ignored while lines nonzero
    lines(3'b100); cyc(2);
    chk("t3_lvl30", bus.level, 1);
    lines(3'b110); cyc(2);
    chk("t3_code", bus.fault_code, 1);
    bus.clear_fault = 1'b1; cyc(3);
    chk("t3_hold_fault", bus.fault, 1);
    chk("t3_hold_code", bus.fault_code, 1);
    lines(3'b000); cyc(2);
    bus.clear_fault = 1'b0;
    chk("t3_exit_fault", bus.fault, 0);
    chk("t3_exit_code", bus.fault_code, 0);
    chk("t3_exit_level", bus.level, 0);

    // 4) dwell violation; tick on state entry not counted
    lines(3'b100); cyc(2);
    tick_pulse();
    lines(3'b010); cyc(2);
    chk("t4_code", bus.fault_code, 3);
    clear_to_idle();
    lines(3'b100); cyc(1);
    tick_pulse();
    chk("t4b_lvl30", bus.level, 1);
    tick_pulse();
    lines(3'b010); cyc(2);
    chk("t4b_code", bus.fault_code, 3);
    clear_to_idle();

    // 5) 30 -> 50 mid-period: finish 3-cycle pulse, then 5-cycle pulses
    lines(3'b100); cyc(2);
    tick_pulse(); tick_pulse();
    cyc(11);
    wait_rise(f);
    chk("t5_rise1", f, 1);
    lines(3'b010);
    hi_run(n);
    chk("t5_run_old", n, 3);
    wait_rise(f);
    chk("t5_rise2", f, 1);
    hi_run(n);
    chk("t5_run_new", n, 5);
    chk("t5_lvl50", bus.level, 2);

    // 6) async reset in RUN100 and in FAULT, then ena freeze
    tick_pulse(); tick_pulse();
    lines(3'b001); cyc(2);
    chk("t6_lvl100", bus.level, 3);
    cyc(12);
    chk("t6_pwm_on", bus.pwm_out, 1);
    #3 reset = 1'b1;
    #1;
    chk("t6_rst_level", bus.level, 0);
    chk("t6_rst_pwm", bus.pwm_out, 0);
    cyc(1);
    reset = 1'b0;
    cyc(2);
    chk("t6_fault", bus.fault, 1);
    chk("t6_fault_code", bus.fault_code, 2);
    #3 reset = 1'b1;
    #1;
    chk("t6_rst_fault", bus.fault, 0);
    chk("t6_rst_code", bus.fault_code, 0);
    lines(3'b000);
    cyc(1);
    reset = 1'b0;

    lines(3'b100); cyc(2);
    tick_pulse();
    cyc(11);
    bus.ena = 1'b0;
    cyc(1);
    chk("t6_ena_pwm", bus.pwm_out, 0);
    tick_pulse();
    lines(3'b010); cyc(3);
    chk("t6_ena_level", bus.level, 1);
    chk("t6_ena_pwm_hold", bus.pwm_out, 0);
    chk("t6_ena_nofault", bus.fault, 0);
    bus.ena = 1'b1;
    cyc(2);
    chk("t6_resume_code", bus.fault_code, 3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
